clk_div_ratio_ctrl: RTL and testbench
=====================================

// Module: clk_div_ratio_ctrl
// PURPOSE
//   Run-time controller for the 2/4/8/16 clock-divider path.
//   - Owns one free-running divide counter that produces the selected divided clock.
//   - Accepts ratio-change requests from two sources:
//       - a valid/ready port (software or FSM);
//       - a debounced pushbutton step pulse.
//   - Applies the new ratio only at the common counter wrap, so div_clk_out never glitches.
//   - Enforces one settle period after each switch.
// PARAMETERS
//   CNT_W      4      divide counter width; fixed at 4 for SEL_W=2 (max ratio 16)
//   SEL_W      2      select width; ratio = 2^(sel+1)
//   RESET_SEL  2'b00  ratio select loaded at reset (00 -> /2)
//   BTN_WRAP   1      1: button step wraps 3->0; 0: button saturates at 3
// PORTS
//   clock_in     input   1      input clock; all logic on rising edge
//   reset        input   1      asynchronous, active-high reset
//   req_valid    input   1      ratio-change request valid
//   req_sel      input   2      requested select (00:/2 01:/4 10:/8 11:/16)
//   req_ready    output  1      high only in IDLE; handshake = req_valid & req_ready
//   btn_step     input   1      1-cycle pulse from debouncer: advance select by 1
//   sel_active   output  2      select currently driving div_clk_out
//   div_clk_out  output  1      registered divided clock, 50% duty
//   switch_done  output  1      1-cycle pulse when a request is retired
//   busy         output  1      high in PEND or SETTLE
// BEHAVIOUR
//   Reset (async, immediate, also mid-operation):
//     - cnt=0, sel_active=RESET_SEL, div_clk_out=0, switch_done=0, state=IDLE.
//     - Any pending request is discarded; busy=0, req_ready=1.
//   Counter:
//     - cnt increments by 1 every cycle, wraps 15->0, never stalls.
//     - "wrap edge" = the edge where cnt goes 15->0.
//   Output:
//     - div_clk_out is a flop loaded with next-cnt[next-sel_active]; it always equals cnt[sel_active].
//     - Period is 2^(sel_active+1) cycles.
//   State IDLE (req_ready=1, busy=0):
//     - req_valid accepted: latch pend_sel=req_sel.
//         - req_sel==sel_active: stay IDLE; switch_done=1 next cycle; no other change.
//         - otherwise: go to PEND.
//     - btn_step with no req_valid: pend_sel=sel_active+1.
//         - At 3: wraps to 0 if BTN_WRAP=1, else stays 3.
//         - Then handled exactly as a request.
//     - req_valid and btn_step in the same cycle: req wins, btn_step dropped.
//   State PEND (busy=1, req_ready=0):
//     - btn_step ignored.
//     - On the first wrap edge after entry: sel_active<=pend_sel, cnt->0, div_clk_out->0,
//       switch_done=1 for the following cycle, state->SETTLE.
//     - If accepted on a wrap edge, the switch happens on the NEXT wrap (16 cycles later).
//   State SETTLE (busy=1, req_ready=0):
//     - Inputs ignored.
//     - Returns to IDLE on the next wrap edge (exactly 16 cycles after the switch).
//   Latency:
//     - Accept to switch: 1..16 cycles.
//     - Accept to req_ready high again: 17..32 cycles.
//   Glitch-freedom:
//     - At a switch, all cnt bits are 0, so the old ratio ends low and the new one starts low.
//     - No high pulse on div_clk_out shorter than the smaller ratio's half-period.
// TESTING
//   1 Reset:
//       - Assert reset mid-PEND.
//       - Required: outputs at reset values immediately; sel_active=RESET_SEL; no switch_done after release.
//   2 Ratios:
//       - Request sel 0,1,2,3 in turn.
//       - Required: div_clk_out periods 2,4,8,16 cycles with 50% duty; switch_done once per request.
//   3 Alignment:
//       - Request sel=3 while cnt=5.
//       - Required: busy for 10+16 cycles.
//       - Required: sel_active changes on the 15->0 edge; div_clk_out 0 at that edge.
//       - Required: req_ready back high 26 cycles after accept.
//   4 Same-select:
//       - Request sel==sel_active.
//       - Required: switch_done the next cycle; busy stays 0; div_clk_out unchanged.
//   5 Button:
//       - 4 btn_step pulses from sel=0, each spaced past SETTLE.
//       - Required: sel 1,2,3,0 with BTN_WRAP=1; sel 1,2,3,3 with BTN_WRAP=0.
//       - Required: btn_step while busy has no effect.
//   6 Collision:
//       - req_valid(sel=2) and btn_step in the same IDLE cycle from sel=0.
//       - Required: final sel_active=2; only one switch_done.

Source files
------------

// File: rtl/clk_div_ratio_ctrl.sv
// clk_div_ratio_ctrl
//   Run-time controller for the 2/4/8/16 clock-divider path. A free-running
//   4-bit counter produces the divided clock; ratio changes requested over a
//   valid/ready port or by a debounced button step are applied only at the
//   counter wrap (all counter bits zero), followed by one full settle period.
//
// Ports
//   clock_in     in   input clock, all logic on the rising edge
//   reset        in   asynchronous active-high reset
//   req_valid    in   ratio-change request valid
//   req_sel      in   requested select (00:/2 01:/4 10:/8 11:/16)
//   req_ready    out  high only while idle
//   btn_step     in   one-cycle pulse: advance select by one
//   sel_active   out  select currently driving div_clk_out
//   div_clk_out  out  registered divided clock, 50% duty
//   switch_done  out  one-cycle pulse when a request is retired
//   busy         out  high while a switch is pending or settling
module clk_div_ratio_ctrl #(
  parameter int               CNT_W     = 4,
  parameter int               SEL_W     = 2,
  parameter logic [SEL_W-1:0] RESET_SEL = 2'b00,
  parameter bit               BTN_WRAP  = 1'b1
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [SEL_W-1:0] req_sel,
  output logic             req_ready,
  input  logic             btn_step,
  output logic [SEL_W-1:0] sel_active,
  output logic             div_clk_out,
  output logic             switch_done,
  output logic             busy
);

  localparam logic [1:0]       ST_IDLE   = 2'd0;
  localparam logic [1:0]       ST_PEND   = 2'd1;
  localparam logic [1:0]       ST_SETTLE = 2'd2;
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [SEL_W-1:0] SEL_MAX   = {SEL_W{1'b1}};
  localparam logic [SEL_W-1:0] SEL_ONE   = {{(SEL_W-1){1'b0}}, 1'b1};
  localparam logic [SEL_W-1:0] SEL_ZERO  = {SEL_W{1'b0}};

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [SEL_W-1:0] pend_sel_r;
  logic [SEL_W-1:0] pend_nxt_s;
  logic [SEL_W-1:0] sel_nxt_s;
  logic [SEL_W-1:0] btn_sel_s;
  logic             wrap_s;
  logic             done_nxt_s;
  logic             div_nxt_s;

  // Counter next value, wrap detect and the select a button step would ask for.
  always_comb begin
    cnt_nxt_s = cnt_r + CNT_ONE;
    wrap_s    = (cnt_r == CNT_MAX);
    btn_sel_s = sel_active + SEL_ONE;
    if (sel_active == SEL_MAX) begin
      btn_sel_s = BTN_WRAP ? SEL_ZERO : SEL_MAX;
    end else begin
      btn_sel_s = sel_active + SEL_ONE;
    end
  end

  // Control state machine: accept in IDLE, switch at wrap in PEND, hold one
  // full counter period in SETTLE.
  always_comb begin
    state_nxt_s = state_r;
    pend_nxt_s  = pend_sel_r;
    sel_nxt_s   = sel_active;
    done_nxt_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // A request in the same cycle as a button step wins; the step is dropped.
        if (req_valid) begin
          pend_nxt_s = req_sel;
          if (req_sel == sel_active) begin
            done_nxt_s = 1'b1;
          end else begin
            state_nxt_s = ST_PEND;
          end
        end else if (btn_step) begin
          pend_nxt_s = btn_sel_s;
          if (btn_sel_s == sel_active) begin
            done_nxt_s = 1'b1;
          end else begin
            state_nxt_s = ST_PEND;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PEND: begin
        // The counter rolls to zero on this edge, so both old and new
        // ratios are low here and the switch cannot glitch.
        if (wrap_s) begin
          sel_nxt_s   = pend_sel_r;
          done_nxt_s  = 1'b1;
          state_nxt_s = ST_SETTLE;
        end else begin
          state_nxt_s = ST_PEND;
        end
      end
      ST_SETTLE: begin
        if (wrap_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_SETTLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
    // Loading the flop from the next counter/select keeps div_clk_out equal
    // to cnt[sel_active] every cycle.
    div_nxt_s = cnt_nxt_s[sel_nxt_s];
  end

  // State, counter and registered outputs.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      pend_sel_r  <= RESET_SEL;
      sel_active  <= RESET_SEL;
      div_clk_out <= 1'b0;
      switch_done <= 1'b0;
      req_ready   <= 1'b1;
      busy        <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      pend_sel_r  <= pend_nxt_s;
      sel_active  <= sel_nxt_s;
      div_clk_out <= div_nxt_s;
      switch_done <= done_nxt_s;
      req_ready   <= (state_nxt_s == ST_IDLE);
      busy        <= (state_nxt_s != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_clk_div_ratio_ctrl.sv
// tb_clk_div_ratio_ctrl
//   Self-checking bench for clk_div_ratio_ctrl. The reference model counts
//   clock edges since reset and schedules each switch as an absolute edge
//   number; expected outputs follow from that with plain arithmetic.
module tb_clk_div_ratio_ctrl;

  localparam bit         BTN_WRAP  = 1'b1;
  localparam logic [1:0] RESET_SEL = 2'b00;

  logic       clock_in;
  logic       reset;
  logic       req_valid;
  logic [1:0] req_sel;
  logic       req_ready;
  logic       btn_step;
  logic [1:0] sel_active;
  logic       div_clk_out;
  logic       switch_done;
  logic       busy;

  clk_div_ratio_ctrl #(
    .CNT_W     (4),
    .SEL_W     (2),
    .RESET_SEL (RESET_SEL),
    .BTN_WRAP  (BTN_WRAP)
  ) dut (
    .clock_in    (clock_in),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_sel     (req_sel),
    .req_ready   (req_ready),
    .btn_step    (btn_step),
    .sel_active  (sel_active),
    .div_clk_out (div_clk_out),
    .switch_done (switch_done),
    .busy        (busy)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  int n_tests;
  int n_fail;

  // Reference model state: edges since reset release, active ratio, and the
  // absolute edge numbers of the pending switch, end of busy and done pulse.
  int m_n;
  int m_sel;
  int m_pend_sel;
  int m_switch_at;
  int m_busy_until;
  int m_done_at;
  bit m_pending;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, m_n);
    end
  endtask

  task automatic model_reset();
    m_n          = 0;
    m_sel        = int'(RESET_SEL);
    m_pend_sel   = 0;
    m_switch_at  = -1;
    m_busy_until = 0;
    m_done_at    = -1;
    m_pending    = 1'b0;
  endtask

  function automatic int btn_target(input int s);
    if (s == 3) return BTN_WRAP ? 0 : 3;
    return s + 1;
  endfunction

  // Advance the model by one clock edge given the inputs present before it.
  task automatic model_edge(input bit v, input int s, input bit b);
    int e;
    int c;
    int k;
    int tgt;
    bit acc;
    e   = m_n + 1;
    acc = 1'b0;
    tgt = 0;
    if (m_pending && e == m_switch_at) begin
      m_sel     = m_pend_sel;
      m_done_at = e;
      m_pending = 1'b0;
    end
    if (m_n >= m_busy_until) begin
      if (v) begin acc = 1'b1; tgt = s; end
      else if (b) begin acc = 1'b1; tgt = btn_target(m_sel); end
    end
    if (acc) begin
      if (tgt == m_sel) begin
        m_done_at = e;
      end else begin
        c            = m_n % 16;
        k            = (c == 15) ? 16 : (15 - c);
        m_pend_sel   = tgt;
        m_pending    = 1'b1;
        m_switch_at  = e + k;
        m_busy_until = e + k + 16;
      end
    end
    m_n = e;
  endtask

  task automatic check_all();
    int exp_busy;
    exp_busy = (m_n < m_busy_until) ? 1 : 0;
    check_eq("div_clk_out", int'(div_clk_out), ((m_n % 16) >> m_sel) & 1);
    check_eq("sel_active", int'(sel_active), m_sel);
    check_eq("busy", int'(busy), exp_busy);
    check_eq("req_ready", int'(req_ready), 1 - exp_busy);
    check_eq("switch_done", int'(switch_done), (m_done_at == m_n) ? 1 : 0);
  endtask

  // One clock: drive inputs away from the edge, step the model, sample after.
  task automatic step(input bit v, input int s, input bit b);
    req_valid = v;
    req_sel   = 2'(s);
    btn_step  = b;
    model_edge(v, s, b);
    @(posedge clock_in);
    #1;
    check_all();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (m_n >= m_busy_until) break;
      step(1'b0, 0, 1'b0);
    end
    check_eq("idle_reached", int'(req_ready), 1);
  endtask

  initial begin
    int cnt;
    int dones;
    int rises;
    int highs;
    int prev;
    int exp_btn[4];
    n_tests   = 0;
    n_fail    = 0;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_sel   = 2'b00;
    btn_step  = 1'b0;
    model_reset();

    // Reset values while reset is held.
    #2;
    check_eq("rst_div", int'(div_clk_out), 0);
    check_eq("rst_sel", int'(sel_active), int'(RESET_SEL));
    check_eq("rst_done", int'(switch_done), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_ready", int'(req_ready), 1);
    @(posedge clock_in); #1;
    @(posedge clock_in); #1;
    reset = 1'b0;
    model_reset();

    // Reset asserted in the middle of a pending switch.
    for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b0);
    step(1'b1, 2, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b0);
    check_eq("pend_busy", int'(busy), 1);
    #3;
    reset = 1'b1;
    #1;
    check_eq("mid_rst_sel", int'(sel_active), int'(RESET_SEL));
    check_eq("mid_rst_div", int'(div_clk_out), 0);
    check_eq("mid_rst_busy", int'(busy), 0);
    check_eq("mid_rst_ready", int'(req_ready), 1);
    check_eq("mid_rst_done", int'(switch_done), 0);
    @(posedge clock_in); #1;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 40; i++) step(1'b0, 0, 1'b0);

    // Same-select request retires at once without going busy.
    step(1'b1, 0, 1'b0);
    check_eq("same_done", int'(switch_done), 1);
    check_eq("same_busy", int'(busy), 0);
    step(1'b0, 0, 1'b0);

    // Request and button in the same idle cycle: the request wins.
    dones = 0;
    step(1'b1, 2, 1'b1);
    for (int i = 0; i < 40; i++) begin
      dones += int'(switch_done);
      if (m_n >= m_busy_until) break;
      step(1'b0, 0, 1'b0);
    end
    check_eq("coll_sel", int'(sel_active), 2);
    check_eq("coll_dones", dones, 1);

    // Alignment: accept sel=3 while the counter is at 5.
    while (m_n % 16 != 5) step(1'b0, 0, 1'b0);
    step(1'b1, 3, 1'b0);
    cnt = 0;
    while (!req_ready && cnt < 40) begin
      step(1'b0, 0, 1'b0);
      cnt++;
    end
    check_eq("align_busy_cycles", cnt, 26);

    // Each ratio in turn: one done per request, then period and duty.
    for (int s = 0; s < 4; s++) begin
      dones = 0;
      step(1'b1, s, 1'b0);
      dones += int'(switch_done);
      for (int i = 0; i < 40 && m_n < m_busy_until; i++) begin
        step(1'b0, 0, 1'b0);
        dones += int'(switch_done);
      end
      check_eq("ratio_dones", dones, 1);
      rises = 0;
      highs = 0;
      prev  = int'(div_clk_out);
      for (int i = 0; i < 32; i++) begin
        step(1'b0, 0, 1'b0);
        if (div_clk_out && prev == 0) rises++;
        highs += int'(div_clk_out);
        prev = int'(div_clk_out);
      end
      check_eq("ratio_rises", rises, 32 >> (s + 1));
      check_eq("ratio_high_cycles", highs, 16);
    end

    // Button steps from sel 0, with an ignored press while busy.
    step(1'b1, 0, 1'b0);
    wait_idle();
    exp_btn[0] = 1;
    exp_btn[1] = 2;
    exp_btn[2] = 3;
    exp_btn[3] = BTN_WRAP ? 0 : 3;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 0, 1'b1);
      step(1'b0, 0, 1'b0);
      step(1'b0, 0, 1'b1);
      wait_idle();
      check_eq("btn_sel", int'(sel_active), exp_btn[i]);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom % 8) == 0, int'($urandom % 4), ($urandom % 6) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
